// File: rtl/pipeline_exe_muldiv_pkg.sv
// Shared encodings for the EXE stage: ALU op codes, DMEM access types, result-source bits, forwarding selects.
package pipeline_exe_muldiv_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_op_e;

    localparam logic [3:0] DMEM_LB  = 4'd0;
    localparam logic [3:0] DMEM_LH  = 4'd1;
    localparam logic [3:0] DMEM_LW  = 4'd2;
    localparam logic [3:0] DMEM_LBU = 4'd3;
    localparam logic [3:0] DMEM_LHU = 4'd4;
    localparam logic [3:0] DMEM_SB  = 4'd5;
    localparam logic [3:0] DMEM_SH  = 4'd6;
    localparam logic [3:0] DMEM_SW  = 4'd7;
    localparam logic [3:0] DMEM_NO  = 4'hF;

    localparam int RESULT_SRC_ALU = 0;
    localparam int RESULT_SRC_IMM = 1;
    localparam int RESULT_SRC_MEM = 2;
    localparam int RESULT_SRC_PC4 = 3;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/rv32_divider.sv
// Iterative restoring RV32M divider on operand magnitudes, one quotient bit per cycle, sign fixed up at the end.
// Operands are captured on start; flush aborts to IDLE and drops any partial result.
module rv32_divider
    import pipeline_exe_muldiv_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        start,
    input  logic        is_signed,
    input  logic        rem_sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [4:0] LAST_STEP = 5'(DIV_CYCLES - 1);

    div_state_e  state, state_nxt;
    logic [31:0] quo, rem, dvsr;
    logic [4:0]  cnt;
    logic        neg_q, neg_r, rem_q;
    logic [32:0] trial;
    logic [31:0] a_mag, b_mag;

    assign a_mag = (is_signed && a[31]) ? -a : a;
    assign b_mag = (is_signed && b[31]) ? -b : b;
    assign trial = {rem, quo[31]} - {1'b0, dvsr};

    always_ff @(posedge clk) begin
        if (!resetn) state <= DIV_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (start) state_nxt = DIV_BUSY;
            DIV_BUSY: if (cnt == LAST_STEP) state_nxt = DIV_DONE;
            DIV_DONE: state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
        if (flush) state_nxt = DIV_IDLE;
    end

    // Divide-by-zero falls out naturally: every trial subtract succeeds, giving all-ones and rem = dividend.
    always_ff @(posedge clk) begin
        if (state == DIV_IDLE && start) begin
            quo   <= a_mag;
            rem   <= '0;
            dvsr  <= b_mag;
            neg_q <= is_signed && (a[31] ^ b[31]) && (b != '0);
            neg_r <= is_signed && a[31];
            rem_q <= rem_sel;
            cnt   <= '0;
        end else if (state == DIV_BUSY) begin
            cnt <= cnt + 5'd1;
            if (!trial[32]) begin
                rem <= trial[31:0];
                quo <= {quo[30:0], 1'b1};
            end else begin
                rem <= {rem[30:0], quo[31]};
                quo <= {quo[30:0], 1'b0};
            end
        end
    end

    assign busy   = (state == DIV_IDLE && start) || (state == DIV_BUSY);
    assign done   = (state == DIV_DONE);
    assign result = rem_q ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);

endmodule

// File: rtl/pipeline_exe_muldiv.sv
// EXE stage: operand forwarding, RV32I ALU, single-cycle multiplier, iterative divider, EX/MEM register.
// Stalls the front end while a divide is in flight; flush and reset load a bubble and abort the divide.
module pipeline_exe_muldiv
    import pipeline_exe_muldiv_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush_e_i,
    input  logic [31:0] rs1_d_i,
    input  logic [31:0] rs2_d_i,
    input  logic [31:0] imm_d_i,
    input  logic [31:0] pc_d_i,
    input  logic [31:0] pc_plus_d_i,
    input  logic [4:0]  alu_op_d_i,
    input  logic        alu_src_a_d_i,
    input  logic        alu_src_b_d_i,
    input  logic [1:0]  fwd_a_sel_i,
    input  logic [1:0]  fwd_b_sel_i,
    input  logic [31:0] bypass_m_i,
    input  logic [31:0] wb_result_i,
    input  logic [3:0]  dmem_type_d_i,
    input  logic        reg_write_en_d_i,
    input  logic [4:0]  rd_idx_d_i,
    input  logic [3:0]  result_src_d_i,
    output logic        stall_e_o,
    output logic [31:0] alu_result_e_o,
    output logic [31:0] alu_calculation_e_o,
    output logic [31:0] rs2_e_o,
    output logic [31:0] extended_imm_e_o,
    output logic [31:0] pc_plus_e_o,
    output logic [3:0]  dmem_type_e_o,
    output logic        reg_write_en_e_o,
    output logic [4:0]  rd_idx_e_o,
    output logic [3:0]  result_src_e_o
);

    logic [31:0] fwd_rs1, fwd_rs2, src_a, src_b, alu_res, div_result;
    logic [63:0] mul_a, mul_b, product;
    logic        a_signed, b_signed, div_start, div_busy, div_done;

    always_comb begin
        case (fwd_a_sel_i)
            FWD_M:   fwd_rs1 = bypass_m_i;
            FWD_WB:  fwd_rs1 = wb_result_i;
            default: fwd_rs1 = rs1_d_i;
        endcase
        case (fwd_b_sel_i)
            FWD_M:   fwd_rs2 = bypass_m_i;
            FWD_WB:  fwd_rs2 = wb_result_i;
            default: fwd_rs2 = rs2_d_i;
        endcase
    end

    assign src_a = alu_src_a_d_i ? pc_d_i  : fwd_rs1;
    assign src_b = alu_src_b_d_i ? imm_d_i : fwd_rs2;

    // One 64x64 multiply on sign/zero-extended operands covers all four MUL variants.
    assign a_signed = (alu_op_d_i == ALU_MULH) || (alu_op_d_i == ALU_MULHSU);
    assign b_signed = (alu_op_d_i == ALU_MULH);
    assign mul_a    = {{32{a_signed & src_a[31]}}, src_a};
    assign mul_b    = {{32{b_signed & src_b[31]}}, src_b};
    assign product  = mul_a * mul_b;

    always_comb begin
        alu_res = '0;
        case (alu_op_d_i)
            ALU_ADD:    alu_res = src_a + src_b;
            ALU_SUB:    alu_res = src_a - src_b;
            ALU_SLL:    alu_res = src_a << src_b[4:0];
            ALU_SRL:    alu_res = src_a >> src_b[4:0];
            ALU_SRA:    alu_res = $signed(src_a) >>> src_b[4:0];
            ALU_SLT:    alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
            ALU_SLTU:   alu_res = {31'd0, src_a < src_b};
            ALU_XOR:    alu_res = src_a ^ src_b;
            ALU_OR:     alu_res = src_a | src_b;
            ALU_AND:    alu_res = src_a & src_b;
            ALU_MUL:    alu_res = product[31:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  alu_res = product[63:32];
            default:    alu_res = '0;
        endcase
    end

    assign div_start = is_div_op(alu_op_d_i) && !flush_e_i && resetn;

    rv32_divider #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush_e_i),
        .start     (div_start),
        .is_signed ((alu_op_d_i == ALU_DIV) || (alu_op_d_i == ALU_REM)),
        .rem_sel   ((alu_op_d_i == ALU_REM) || (alu_op_d_i == ALU_REMU)),
        .a         (fwd_rs1),
        .b         (fwd_rs2),
        .busy      (div_busy),
        .done      (div_done),
        .result    (div_result)
    );

    assign stall_e_o = div_busy && !flush_e_i && resetn;

    always_ff @(posedge clk) begin
        if (!resetn || flush_e_i) begin
            alu_result_e_o      <= '0;
            alu_calculation_e_o <= '0;
            rs2_e_o             <= '0;
            extended_imm_e_o    <= '0;
            pc_plus_e_o         <= '0;
            dmem_type_e_o       <= DMEM_NO;
            reg_write_en_e_o    <= 1'b0;
            rd_idx_e_o          <= '0;
            result_src_e_o      <= '0;
        end else begin
            alu_result_e_o      <= div_done ? div_result : alu_res;
            alu_calculation_e_o <= fwd_rs1 + imm_d_i;
            rs2_e_o             <= fwd_rs2;
            extended_imm_e_o    <= imm_d_i;
            pc_plus_e_o         <= pc_plus_d_i;
            rd_idx_e_o          <= rd_idx_d_i;
            dmem_type_e_o       <= stall_e_o ? DMEM_NO : dmem_type_d_i;
            reg_write_en_e_o    <= reg_write_en_d_i && !stall_e_o;
            result_src_e_o      <= stall_e_o ? 4'd0 : result_src_d_i;
        end
    end

endmodule

// File: tb/tb_pipeline_exe_muldiv.sv
// Directed bench for the EXE stage: table of single-cycle ALU/MUL vectors plus divider, flush and reset sequences.
module tb_pipeline_exe_muldiv;
    import pipeline_exe_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush_e_i = 1'b0;
    logic [31:0] rs1_d_i = '0, rs2_d_i = '0, imm_d_i = '0, pc_d_i = '0, pc_plus_d_i = '0;
    logic [4:0]  alu_op_d_i = ALU_ADD;
    logic        alu_src_a_d_i = 1'b0, alu_src_b_d_i = 1'b0;
    logic [1:0]  fwd_a_sel_i = 2'b00, fwd_b_sel_i = 2'b00;
    logic [31:0] bypass_m_i = '0, wb_result_i = '0;
    logic [3:0]  dmem_type_d_i = DMEM_NO;
    logic        reg_write_en_d_i = 1'b0;
    logic [4:0]  rd_idx_d_i = '0;
    logic [3:0]  result_src_d_i = '0;
    logic        stall_e_o;
    logic [31:0] alu_result_e_o, alu_calculation_e_o, rs2_e_o, extended_imm_e_o, pc_plus_e_o;
    logic [3:0]  dmem_type_e_o;
    logic        reg_write_en_e_o;
    logic [4:0]  rd_idx_e_o;
    logic [3:0]  result_src_e_o;

    pipeline_exe_muldiv #(.DIV_CYCLES(32)) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .flush_e_i           (flush_e_i),
        .rs1_d_i             (rs1_d_i),
        .rs2_d_i             (rs2_d_i),
        .imm_d_i             (imm_d_i),
        .pc_d_i              (pc_d_i),
        .pc_plus_d_i         (pc_plus_d_i),
        .alu_op_d_i          (alu_op_d_i),
        .alu_src_a_d_i       (alu_src_a_d_i),
        .alu_src_b_d_i       (alu_src_b_d_i),
        .fwd_a_sel_i         (fwd_a_sel_i),
        .fwd_b_sel_i         (fwd_b_sel_i),
        .bypass_m_i          (bypass_m_i),
        .wb_result_i         (wb_result_i),
        .dmem_type_d_i       (dmem_type_d_i),
        .reg_write_en_d_i    (reg_write_en_d_i),
        .rd_idx_d_i          (rd_idx_d_i),
        .result_src_d_i      (result_src_d_i),
        .stall_e_o           (stall_e_o),
        .alu_result_e_o      (alu_result_e_o),
        .alu_calculation_e_o (alu_calculation_e_o),
        .rs2_e_o             (rs2_e_o),
        .extended_imm_e_o    (extended_imm_e_o),
        .pc_plus_e_o         (pc_plus_e_o),
        .dmem_type_e_o       (dmem_type_e_o),
        .reg_write_en_e_o    (reg_write_en_e_o),
        .rd_idx_e_o          (rd_idx_e_o),
        .result_src_e_o      (result_src_e_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [1:0]  fa;
        logic        sa;
        logic        sb;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    task automatic nop();
        alu_op_d_i = ALU_ADD; reg_write_en_d_i = 1'b0; dmem_type_d_i = DMEM_NO;
        result_src_d_i = 4'd0; fwd_a_sel_i = FWD_RF; fwd_b_sel_i = FWD_RF;
        alu_src_a_d_i = 1'b0; alu_src_b_d_i = 1'b0; flush_e_i = 1'b0;
    endtask

    // Operand a arrives through the MEM bypass and b through WB so operand capture is exercised.
    task automatic start_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        flush_e_i = 1'b0; alu_op_d_i = op; alu_src_a_d_i = 1'b0; alu_src_b_d_i = 1'b0;
        fwd_a_sel_i = FWD_M; fwd_b_sel_i = FWD_WB; bypass_m_i = a; wb_result_i = b;
        rs1_d_i = 32'hDEAD_BEEF; rs2_d_i = 32'hCAFE_F00D; reg_write_en_d_i = 1'b1;
        rd_idx_d_i = 5'd7; result_src_d_i = 4'b0001; dmem_type_d_i = DMEM_NO;
    endtask

    task automatic run_div(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int  cyc;
        bit  bub_ok;
        start_div(op, a, b);
        #1;
        cyc = 0;
        bub_ok = 1'b1;
        while (stall_e_o === 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            if (reg_write_en_e_o !== 1'b0 || result_src_e_o !== 4'd0 || dmem_type_e_o !== DMEM_NO)
                bub_ok = 1'b0;
            bypass_m_i = 32'h1234_5678;
            wb_result_i = 32'h0BAD_F00D;
            cyc++;
        end
        chk({name, "_stall_cycles"}, 32'(cyc), 32'd33);
        chk({name, "_bubbles"}, {31'd0, bub_ok}, 32'd1);
        @(posedge clk); #1;
        chk({name, "_result"}, alu_result_e_o, exp);
        chk({name, "_wen"}, {31'd0, reg_write_en_e_o}, 32'd1);
        nop();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{ALU_ADD,    FWD_M,  1'b0, 1'b1, 32'd5,        32'd0,        32'd7,    32'd12};
        vecs[1]  = '{ALU_ADD,    FWD_RF, 1'b1, 1'b1, 32'h1000,     32'd0,        32'h20,   32'h1020};
        vecs[2]  = '{ALU_SUB,    FWD_RF, 1'b0, 1'b0, 32'd5,        32'd7,        32'd0,    32'hFFFF_FFFE};
        vecs[3]  = '{ALU_SLL,    FWD_RF, 1'b0, 1'b0, 32'd1,        32'h21,       32'd0,    32'd2};
        vecs[4]  = '{ALU_SRL,    FWD_WB, 1'b0, 1'b0, 32'h8000_0000, 32'd4,       32'd0,    32'h0800_0000};
        vecs[5]  = '{ALU_SRA,    FWD_RF, 1'b0, 1'b0, 32'h8000_0000, 32'd4,       32'd0,    32'hF800_0000};
        vecs[6]  = '{ALU_SLT,    FWD_RF, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,       32'd0,    32'd1};
        vecs[7]  = '{ALU_SLTU,   FWD_RF, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,       32'd0,    32'd0};
        vecs[8]  = '{ALU_XOR,    FWD_RF, 1'b0, 1'b0, 32'hF0F0,     32'hFF00,     32'd0,    32'h0FF0};
        vecs[9]  = '{ALU_OR,     FWD_RF, 1'b0, 1'b0, 32'hF0,       32'h0F,       32'd0,    32'hFF};
        vecs[10] = '{ALU_AND,    FWD_RF, 1'b0, 1'b0, 32'hF0,       32'h3C,       32'd0,    32'h30};
        vecs[11] = '{ALU_MUL,    FWD_RF, 1'b0, 1'b0, 32'd7,        32'd6,        32'd0,    32'd42};
        vecs[12] = '{ALU_MUL,    FWD_RF, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2,       32'd0,    32'hFFFF_FFFE};
        vecs[13] = '{ALU_MULH,   FWD_RF, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'd0,  32'h4000_0000};
        vecs[14] = '{ALU_MULHU,  FWD_RF, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,  32'hFFFF_FFFE};
        vecs[15] = '{ALU_MULHSU, FWD_RF, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,  32'hFFFF_FFFF};
        vecs[16] = '{ALU_MULH,   FWD_RF, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,  32'd0};
        vecs[17] = '{ALU_SLT,    FWD_RF, 1'b0, 1'b0, 32'd5,        32'hFFFF_FFFB, 32'd0,   32'd0};

        // Reset with a divide op present: outputs at reset values, no stall.
        alu_op_d_i = ALU_DIV; reg_write_en_d_i = 1'b1; dmem_type_d_i = DMEM_SW;
        result_src_d_i = 4'b0001; rd_idx_d_i = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", {31'd0, stall_e_o}, 32'd0);
        chk("reset_alu_result", alu_result_e_o, 32'd0);
        chk("reset_calc", alu_calculation_e_o, 32'd0);
        chk("reset_rs2", rs2_e_o, 32'd0);
        chk("reset_dmem", {28'd0, dmem_type_e_o}, {28'd0, DMEM_NO});
        chk("reset_wen", {31'd0, reg_write_en_e_o}, 32'd0);
        chk("reset_result_src", {28'd0, result_src_e_o}, 32'd0);
        chk("reset_rd", {27'd0, rd_idx_e_o}, 32'd0);
        nop();
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            nop();
            alu_op_d_i = vecs[i].op;
            fwd_a_sel_i = vecs[i].fa;
            alu_src_a_d_i = vecs[i].sa;
            alu_src_b_d_i = vecs[i].sb;
            rs1_d_i = 32'hDEAD_BEEF; bypass_m_i = 32'h5555_AAAA; wb_result_i = 32'h3333_CCCC;
            pc_d_i = 32'h0;
            if (vecs[i].sa) pc_d_i = vecs[i].a;
            else begin
                case (vecs[i].fa)
                    FWD_M:   bypass_m_i = vecs[i].a;
                    FWD_WB:  wb_result_i = vecs[i].a;
                    default: rs1_d_i = vecs[i].a;
                endcase
            end
            rs2_d_i = vecs[i].b;
            imm_d_i = vecs[i].imm;
            reg_write_en_d_i = 1'b1;
            rd_idx_d_i = 5'(i);
            result_src_d_i = 4'b0001;
            #1;
            chk($sformatf("vec%0d_stall", i), {31'd0, stall_e_o}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_result", i), alu_result_e_o, vecs[i].exp);
            if (i == 0) begin
                chk("vec0_wen", {31'd0, reg_write_en_e_o}, 32'd1);
                chk("vec0_rd", {27'd0, rd_idx_e_o}, 32'd0);
                chk("vec0_result_src", {28'd0, result_src_e_o}, 32'd1);
            end
            if (i == 5) chk("vec5_rd", {27'd0, rd_idx_e_o}, 32'd5);
        end

        // Store: address from rs1+imm, store data forwarded from WB.
        @(negedge clk);
        nop();
        rs1_d_i = 32'h100; imm_d_i = 32'h8; alu_src_b_d_i = 1'b1; fwd_b_sel_i = FWD_WB;
        wb_result_i = 32'hAB; rs2_d_i = 32'h7777_7777; dmem_type_d_i = DMEM_SW;
        pc_plus_d_i = 32'h204;
        @(posedge clk); #1;
        chk("sw_addr", alu_calculation_e_o, 32'h108);
        chk("sw_data", rs2_e_o, 32'hAB);
        chk("sw_dmem", {28'd0, dmem_type_e_o}, {28'd0, DMEM_SW});
        chk("sw_imm", extended_imm_e_o, 32'h8);
        chk("sw_pc_plus", pc_plus_e_o, 32'h204);
        chk("sw_wen", {31'd0, reg_write_en_e_o}, 32'd0);
        nop();

        run_div("div_neg", ALU_DIV,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA);
        run_div("rem_neg", ALU_REM,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE);
        run_div("divu_z",  ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_div("remu_z",  ALU_REMU, 32'd5, 32'd0, 32'd5);
        run_div("div_ovf", ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_div("rem_ovf", ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_div("divu",    ALU_DIVU, 32'd100, 32'd7, 32'd14);
        run_div("remu",    ALU_REMU, 32'd100, 32'd7, 32'd2);
        run_div("div_nb",  ALU_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_div("rem_nb",  ALU_REM,  32'd7, 32'hFFFF_FFFE, 32'd1);
        run_div("div_sz",  ALU_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
        run_div("rem_sz",  ALU_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);

        // Flush mid-divide: stall drops immediately, nothing written back.
        start_div(ALU_DIV, 32'd1000, 32'd9);
        repeat (10) @(posedge clk);
        #1;
        chk("flush_pre_stall", {31'd0, stall_e_o}, 32'd1);
        flush_e_i = 1'b1;
        #1;
        chk("flush_stall_drop", {31'd0, stall_e_o}, 32'd0);
        @(posedge clk); #1;
        chk("flush_no_wb", {31'd0, reg_write_en_e_o}, 32'd0);
        chk("flush_dmem", {28'd0, dmem_type_e_o}, {28'd0, DMEM_NO});
        nop();
        run_div("div_after_flush", ALU_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA);

        // Reset mid-divide behaves like a flush with reset values.
        start_div(ALU_DIVU, 32'd50, 32'd6);
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("rst_mid_stall", {31'd0, stall_e_o}, 32'd0);
        @(posedge clk); #1;
        chk("rst_mid_result", alu_result_e_o, 32'd0);
        chk("rst_mid_wen", {31'd0, reg_write_en_e_o}, 32'd0);
        chk("rst_mid_dmem", {28'd0, dmem_type_e_o}, {28'd0, DMEM_NO});
        resetn = 1'b1;
        run_div("divu_after_rst", ALU_DIVU, 32'd50, 32'd6, 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
